// File: rtl/ram_loader_pkg.sv
// Shared constants and FSM state encoding for the RAM program loader.
package ram_loader_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RAM_DEPTH = 16;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        VERIFY,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams a 16-byte program from a byte source into RAM while holding the CPU off the bus.
// Define LOADER_VERIFY_EN to add a checksum readback pass after the last write.
module ram_loader
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [DATA_W-1:0] ld_data_8,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ram_in,
    output logic              ram_out,
    output logic [ADDR_W-1:0] ram_add_4,
    inout  wire  [DATA_W-1:0] ram_bus_8,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [DATA_W-1:0] sum, sum_next;
    logic [DATA_W-1:0] data, data_next;
    logic              ld_ready_next;
    logic              ram_in_next;
    logic              busy_next;
    logic              done_next;
`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0] rsum, rsum_next;
    logic              ram_out_next;
    logic              err_next;
`endif

    // Only the WRITE cycle drives the shared bus; ram_in is high exactly then.
    assign ram_bus_8 = ram_in ? data : {DATA_W{1'bz}};
    assign ram_add_4 = addr;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        sum_next   = sum;
        data_next  = data;
`ifdef LOADER_VERIFY_EN
        rsum_next  = rsum;
        err_next   = ld_err;
`endif
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_next = LOAD;
                    addr_next  = '0;
                    sum_next   = '0;
`ifdef LOADER_VERIFY_EN
                    rsum_next  = '0;
                    err_next   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready) begin
                    data_next  = ld_data_8;
                    sum_next   = sum + ld_data_8;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    addr_next  = '0;
`ifdef LOADER_VERIFY_EN
                    state_next = VERIFY;
`else
                    state_next = DONE;
`endif
                end else begin
                    addr_next  = addr + ADDR_W'(1);
                    state_next = LOAD;
                end
            end
`ifdef LOADER_VERIFY_EN
            VERIFY: begin
                // RAM drives the bus combinationally from ram_add_4 this cycle.
                rsum_next = rsum + ram_bus_8;
                if (addr == LAST_ADDR) begin
                    addr_next = '0;
                    if (rsum_next == sum) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end
            ERR: state_next = IDLE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ld_ready_next = (state_next == LOAD);
        ram_in_next   = (state_next == WRITE);
        busy_next     = (state_next == LOAD) || (state_next == WRITE) || (state_next == VERIFY);
        done_next     = (state_next == DONE);
`ifdef LOADER_VERIFY_EN
        ram_out_next  = (state_next == VERIFY);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            sum      <= '0;
            data     <= '0;
            ld_ready <= 1'b0;
            ram_in   <= 1'b0;
            ld_busy  <= 1'b0;
            cpu_hold <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            sum      <= sum_next;
            data     <= data_next;
            ld_ready <= ld_ready_next;
            ram_in   <= ram_in_next;
            ld_busy  <= busy_next;
            cpu_hold <= busy_next;
            ld_done  <= done_next;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsum    <= '0;
            ram_out <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            rsum    <= rsum_next;
            ram_out <= ram_out_next;
            ld_err  <= err_next;
        end
    end
`else
    assign ram_out = 1'b0;
    assign ld_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench: ram_loader plus a 16x8 RAM model on a shared bus, scoreboarded writes.
module tb_ram_loader;

`ifdef LOADER_VERIFY_EN
    localparam int LAT   = 50;
    localparam int READS = 16;
`else
    localparam int LAT   = 34;
    localparam int READS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, ld_start, ld_valid, ld_ready;
    logic       ram_in, ram_out, cpu_hold, ld_busy, ld_done, ld_err;
    logic [7:0] ld_data_8;
    logic [3:0] ram_add_4;
    wire  [7:0] ram_bus_8;

    logic [7:0] mem [16];
    logic [7:0] rd_data;
    logic       corrupt7;
    logic [7:0] pattern [16];

    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];

    int checks, errors;
    int cyc, done_cyc, err_cyc, done_pulses;
    int n_both, n_busz, n_rdo, n_hold, n_wr_out;
    bit aborted;
    logic err_after_start;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ld_start  (ld_start),
        .ld_data_8 (ld_data_8),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ram_in    (ram_in),
        .ram_out   (ram_out),
        .ram_add_4 (ram_add_4),
        .ram_bus_8 (ram_bus_8),
        .cpu_hold  (cpu_hold),
        .ld_busy   (ld_busy),
        .ld_done   (ld_done),
        .ld_err    (ld_err)
    );

    // RAM model; address 7 readback can be corrupted. When neither side should
    // drive, the bench parks 0x00 on the bus so a stray loader drive shows up.
    always @(posedge clk) if (ram_in) mem[ram_add_4] <= ram_bus_8;
    always_comb rd_data = (corrupt7 && ram_add_4 == 4'd7) ? (mem[ram_add_4] ^ 8'h01) : mem[ram_add_4];
    assign ram_bus_8 = ram_out ? rd_data : (!ram_in ? 8'h00 : 8'hzz);

    // Runs one load: drives bytes, pushes expected writes, logs observed writes and protocol events.
    task automatic drive_load(input int period, input int stray_k, input int abort_wr);
        int idx, k, tail;
        bit finished, fin_now;
        idx = 0; k = 0; tail = 0; finished = 1'b0;
        exp_q.delete(); obs_q.delete();
        done_cyc = 0; err_cyc = 0; done_pulses = 0;
        n_both = 0; n_busz = 0; n_rdo = 0; n_hold = 0; n_wr_out = 0;
        aborted = 1'b0; err_after_start = 1'bx;
        @(negedge clk);
        ld_start = 1'b1; ld_valid = 1'b0; cyc = 1;
        while (k < 200 && tail < 4 && !aborted) begin
            @(negedge clk);
            cyc++;
            ld_start = (k == stray_k);
            if (k == 0) err_after_start = ld_err;
            if (ram_in) obs_q.push_back({ram_add_4, ram_bus_8});
            if (ram_in && ram_out) n_both++;
            if (ram_out) n_rdo++;
            if (!ram_in && !ram_out && ram_bus_8 !== 8'h00) n_busz++;
            if (ram_in && (!ld_busy || ld_ready)) n_wr_out++;
            if (ld_done) begin
                done_pulses++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (ld_err && k > 0 && err_cyc == 0) err_cyc = cyc;
            fin_now = ld_done || (ld_err && k > 0);
            if (!finished && !fin_now && !cpu_hold) n_hold++;
            if (fin_now) finished = 1'b1;
            if (finished) tail++;
            if (abort_wr > 0 && obs_q.size() >= abort_wr) begin
                ld_valid = 1'b0; ld_start = 1'b0; rst = 1'b1;
                @(negedge clk);
                aborted = 1'b1;
            end else if (!finished && idx < 16 && (k % period) == 0) begin
                ld_valid  = 1'b1;
                ld_data_8 = pattern[idx];
                if (ld_ready) begin
                    exp_q.push_back({4'(idx), pattern[idx]});
                    idx++;
                end
            end else begin
                ld_valid  = 1'b0;
                ld_data_8 = 8'($urandom);
            end
            k++;
        end
        ld_valid = 1'b0; ld_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b1; ld_data_8 = 8'hA5; corrupt7 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ld_ready, ram_in, ram_out, cpu_hold, ld_busy, ld_done, ld_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000", {ld_ready, ram_in, ram_out, cpu_hold, ld_busy, ld_done, ld_err});
        end
        checks++;
        if (ram_add_4 !== 4'd0) begin
            errors++; $display("FAIL reset_addr got %0d want 0", ram_add_4);
        end
        checks++;
        if (ram_bus_8 !== 8'h00) begin
            errors++; $display("FAIL reset_bus_released got %h want 00 (loader not driving)", ram_bus_8);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_ready, ram_in, cpu_hold, ld_busy, ld_done} !== 5'b0) begin
            errors++;
            $display("FAIL idle_no_start got %b want 00000", {ld_ready, ram_in, cpu_hold, ld_busy, ld_done});
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [11:0] e, o;
        int bad;
        for (int i = 0; i < 16; i++) pattern[i] = (i < 15) ? 8'(8'h1F + 16 * i) : 8'h01;
        drive_load(1, -1, 0);
        checks++;
        if (done_cyc != LAT) begin
            errors++; $display("FAIL stream_latency got %0d want %0d", done_cyc, LAT);
        end
        checks++;
        if (done_pulses != 1) begin
            errors++; $display("FAIL stream_done_pulses got %0d want 1", done_pulses);
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL stream_write_count got %0d want 16", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stream_write got addr %0d data %h want addr %0d data %h", o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== pattern[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stream_ram_contents got %0d bad bytes want 0", bad);
        end
        checks++;
        if (n_rdo != READS) begin
            errors++; $display("FAIL stream_readback_cycles got %0d want %0d", n_rdo, READS);
        end
        checks++;
        if (n_both != 0 || n_busz != 0) begin
            errors++; $display("FAIL stream_bus_rules got overlap %0d stray_drive %0d want 0 0", n_both, n_busz);
        end
        checks++;
        if ({ld_err, ld_busy, cpu_hold} !== 3'b000) begin
            errors++; $display("FAIL stream_end_flags got %b want 000", {ld_err, ld_busy, cpu_hold});
        end
    endtask

    task automatic test_throttle();
        logic [11:0] e, o;
        int bad;
        for (int i = 0; i < 16; i++) pattern[i] = 8'($urandom);
        drive_load(3, -1, 0);
        checks++;
        if (done_pulses != 1) begin
            errors++; $display("FAIL throttle_done_pulses got %0d want 1", done_pulses);
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL throttle_write_count got %0d want 16", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL throttle_write got addr %0d data %h want addr %0d data %h", o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
        checks++;
        if (n_hold != 0 || n_wr_out != 0) begin
            errors++; $display("FAIL throttle_hold_write got hold_drops %0d bad_writes %0d want 0 0", n_hold, n_wr_out);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== pattern[i]) bad++;
        checks++;
        if (bad != 0 || n_busz != 0) begin
            errors++; $display("FAIL throttle_ram got bad_bytes %0d stray_drive %0d want 0 0", bad, n_busz);
        end
    endtask

    task automatic test_start_ignored();
        logic [11:0] e, o;
        for (int i = 0; i < 16; i++) pattern[i] = 8'($urandom);
        drive_load(1, 4, 0);
        checks++;
        if (done_cyc != LAT || done_pulses != 1) begin
            errors++; $display("FAIL start_ignored_done got cycle %0d pulses %0d want %0d 1", done_cyc, done_pulses, LAT);
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL start_ignored_write_count got %0d want 16", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL start_ignored_write got addr %0d data %h want addr %0d data %h", o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e, o;
        int bad;
        for (int i = 0; i < 16; i++) pattern[i] = 8'($urandom);
        drive_load(1, -1, 6);
        checks++;
        if (!aborted) begin
            errors++; $display("FAIL mid_reset_reached got aborted=0 want 1");
        end
        checks++;
        if ({ld_ready, ram_in, ram_out, cpu_hold, ld_busy, ld_done} !== 6'b0 || ram_add_4 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_idle got flags %b addr %0d want 000000 0", {ld_ready, ram_in, ram_out, cpu_hold, ld_busy, ld_done}, ram_add_4);
        end
        checks++;
        if (ram_bus_8 !== 8'h00) begin
            errors++; $display("FAIL mid_reset_bus_released got %h want 00", ram_bus_8);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) pattern[i] = 8'($urandom);
        drive_load(1, -1, 0);
        checks++;
        if (done_cyc != LAT) begin
            errors++; $display("FAIL restart_latency got %0d want %0d", done_cyc, LAT);
        end
        checks++;
        if (obs_q.size() != 16) begin
            errors++; $display("FAIL restart_write_count got %0d want 16", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL restart_write got addr %0d data %h want addr %0d data %h", o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== pattern[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL restart_ram_contents got %0d bad bytes want 0", bad);
        end
    endtask

`ifdef LOADER_VERIFY_EN
    task automatic test_corrupt();
        for (int i = 0; i < 16; i++) pattern[i] = 8'($urandom);
        pattern[7] = 8'h00;
        corrupt7 = 1'b1;
        drive_load(1, -1, 0);
        checks++;
        if (err_cyc != LAT) begin
            errors++; $display("FAIL corrupt_err_cycle got %0d want %0d", err_cyc, LAT);
        end
        checks++;
        if (done_pulses != 0) begin
            errors++; $display("FAIL corrupt_no_done got %0d pulses want 0", done_pulses);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({ld_err, ld_busy, cpu_hold} !== 3'b100) begin
            errors++; $display("FAIL corrupt_err_sticky got %b want 100", {ld_err, ld_busy, cpu_hold});
        end
        corrupt7 = 1'b0;
        drive_load(1, -1, 0);
        checks++;
        if (err_after_start !== 1'b0) begin
            errors++; $display("FAIL corrupt_err_clear got %b want 0", err_after_start);
        end
        checks++;
        if (done_pulses != 1 || ld_err !== 1'b0) begin
            errors++; $display("FAIL corrupt_recover got pulses %0d err %b want 1 0", done_pulses, ld_err);
        end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data_8 = 8'h00; corrupt7 = 1'b0;
        test_reset();
        test_stream();
        test_throttle();
        test_start_ignored();
        test_mid_reset();
`ifdef LOADER_VERIFY_EN
        test_corrupt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock shared with the RAM and CPU.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port ld_start, input, 1 bit: one-cycle request to begin a 16-byte program load.
REQ-004 The block SHALL have port ld_data_8, input, 8 bits: next program byte from the byte source.
REQ-005 The block SHALL have port ld_valid, input, 1 bit: ld_data_8 is valid.
REQ-006 The block SHALL have port ld_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-007 The block SHALL have port ram_in, output, 1 bit: RAM write strobe.
REQ-008 The block SHALL have port ram_out, output, 1 bit: RAM bus-drive (read) enable.
REQ-009 The block SHALL have port ram_add_4, output, 4 bits: RAM address.
REQ-010 The block SHALL have port ram_bus_8, inout, 8 bits: shared data bus, driven only in WRITE.
REQ-011 The block SHALL have port cpu_hold, output, 1 bit: holds the CPU off the bus while busy.
REQ-012 The block SHALL have port ld_busy, output, 1 bit: high from the accepted start until DONE/ERR.
REQ-013 The block SHALL have port ld_done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 The block SHALL have port ld_err, output, 1 bit: sticky verify-mismatch flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, WRITE, VERIFY, DONE and ERR.
REQ-016 IDLE: ld_start=1 SHALL go to LOAD with addr=0 and sum=0, set ld_busy=cpu_hold=1, and clear ld_err.
REQ-017 LOAD: ld_ready SHALL be 1; on ld_valid&&ld_ready the byte SHALL be captured, sum+=byte (mod 256), and the FSM SHALL go to WRITE.
REQ-018 WRITE SHALL last exactly 1 cycle with ram_in=1, ram_add_4=addr and ram_bus_8=captured byte.
REQ-019 After WRITE, addr<15 SHALL increment addr and return to LOAD; addr==15 SHALL wrap addr to 0 and go to VERIFY (LOADER_VERIFY_EN) or DONE.
REQ-020 VERIFY SHALL run 16 cycles, one address per cycle (0..15), with ram_out=1, sampling ram_bus_8 in the same cycle into rsum (mod 256).
REQ-021 After address 15 in VERIFY, rsum==sum SHALL go to DONE, otherwise ERR.
REQ-022 DONE SHALL pulse ld_done for 1 cycle, drop ld_busy and cpu_hold, and go to IDLE.
REQ-023 ERR SHALL set ld_err, drop ld_busy and cpu_hold, and go to IDLE; ld_err SHALL hold until the next accepted ld_start or rst.
REQ-024 ld_start while ld_busy=1 SHALL be ignored.
REQ-025 ram_in and ram_out SHALL never be 1 in the same cycle.
REQ-026 ram_bus_8 SHALL be high-impedance in every state except WRITE.
REQ-027 ld_valid with ld_ready=0 SHALL be ignored, and the byte SHALL NOT be consumed.
REQ-028 Minimum load latency, ld_start to ld_done, SHALL be 1+32 cycles plus the 16-cycle VERIFY when enabled, plus 1 cycle for DONE.

Reset
REQ-029 On rst=1 at a clock edge the block SHALL enter IDLE, including when rst arrives mid-load.
REQ-030 On that reset the outputs SHALL be ram_in=0, ram_out=0, ram_add_4=0, ram_bus_8=Z, ld_ready=0, cpu_hold=0, ld_busy=0, ld_done=0, ld_err=0, and addr, sum and rsum SHALL be 0.

Configuration
REQ-031 With macro LOADER_VERIFY_EN defined, the VERIFY state and checksum compare SHALL be compiled in.
REQ-032 Without LOADER_VERIFY_EN, WRITE at addr 15 SHALL go directly to DONE, ld_err SHALL be tied 0, ram_out SHALL be tied 0, and the rsum logic SHALL be absent.

Structure
REQ-033 Package ram_loader_pkg SHALL hold the state enum and the constants ADDR_W=4, DATA_W=8 and RAM_DEPTH=16.
REQ-034 Tristate driving SHALL be a single continuous assignment in ram_loader, with no sub-module.
REQ-035 The bench SHALL instantiate ram_loader with the existing RAM block on a shared ram_bus_8.

Verification
REQ-036 Bench SHALL check: reset, then ld_start, then bytes 0x1F,0x2F,...,0x01 (16) with ld_valid held high -> 16 ram_in pulses at addresses 0..15, RAM contents equal the inputs, ld_done 1 cycle at 1+32+16+1 cycles.
REQ-037 Bench SHALL check: ld_valid toggling 1-of-3 cycles -> no byte lost or duplicated, ram_in only in WRITE, cpu_hold high throughout.
REQ-038 Bench SHALL check: RAM model forced to corrupt address 7 on readback (0x00->0x01) -> ld_err=1, ld_done stays 0, ld_err stays 1 until the next ld_start.
REQ-039 Bench SHALL check: rst asserted after byte 5 written -> next cycle IDLE, bus Z, ram_in=0, cpu_hold=0; a fresh ld_start restarts at address 0.
REQ-040 Bench SHALL check: ld_start pulsed during LOAD -> ignored, sequence unaffected.
REQ-041 Bench SHALL check: build without LOADER_VERIFY_EN -> ld_done at 1+32+1 cycles, ram_out never 1.
